// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared defaults and helpers for the fetch-to-decode queue
`ifndef INSTR_NOP
`define INSTR_NOP 32'd0
`endif
`ifndef IF_ID_DEPTH
`define IF_ID_DEPTH 2
`endif
package if_id_queue_pkg;
  localparam int unsigned IF_ID_WIDTH = 32;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: register array with synchronous write and asynchronous read
module if_id_queue_mem #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clock) mem_q <= mem_d;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode FIFO with freeze and flush; IF_ID_PERF_CNT_EN adds stall/flush counters
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = `IF_ID_DEPTH,
  parameter int WIDTH = IF_ID_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] if_pc,
  input  logic [WIDTH-1:0] if_instruction,
  input  logic             branch_taken,
  output logic             freeze,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_instruction
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_drops
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic full, push, pop;
  logic [2*WIDTH-1:0] head;
  always_comb begin
    full = count_q == (AW+1)'(DEPTH);
    freeze = full & !branch_taken;
    id_valid = count_q != '0;
    push = !reset & !branch_taken & !full;
    pop = id_valid & id_ready & !branch_taken;
    wr_ptr_d = branch_taken ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = branch_taken ? '0 : rd_ptr_q + AW'(pop);
    count_d = branch_taken ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    id_pc = id_valid ? head[2*WIDTH-1:WIDTH] : '0;
    id_instruction = id_valid ? head[WIDTH-1:0] : WIDTH'(`INSTR_NOP);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  if_id_queue_mem #(.DEPTH(DEPTH), .W(2*WIDTH)) u_mem (
    .clock(clock),
    .we(push),
    .waddr(wr_ptr_q),
    .wdata({if_pc, if_instruction}),
    .raddr(rd_ptr_q),
    .rdata(head)
  );
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d, flush_drops_q, flush_drops_d;
  always_comb begin
    stall_cycles_d = freeze ? sat_add(stall_cycles_q, 32'd1) : stall_cycles_q;
    flush_drops_d = branch_taken ? sat_add(flush_drops_q, 32'(count_q)) : flush_drops_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_drops_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_drops_q <= flush_drops_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_drops = flush_drops_q;
`endif
endmodule
